// File: rtl/uart_transmit.sv
// 8N1 UART transmitter with a small input FIFO.
// Frames are one start bit (0), eight data bits LSB first and one stop bit (1).
// Each bit is held on txd for CLKS_PER_BIT clock cycles.
//
// Handshake: a byte is transferred on a rising clk edge where tx_valid and
// tx_ready are both high. tx_ready depends only on registered FIFO state, so
// it never combinationally depends on tx_valid. tx_data is sampled only on
// that edge, and an offer made while tx_ready is low is simply not taken.
module uart_transmit #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               txd,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count_q;
  logic               push;
  logic               pop;
  logic [7:0]         head;

  // Serialiser state
  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [2:0]    idx_nxt;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          txd_q;
  logic          txd_d;
  logic          bit_end;

  assign tx_ready   = (count_q < FULL_COUNT);
  assign push       = tx_valid && tx_ready;
  assign fifo_count = count_q;
  assign head       = mem[rd_ptr];
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign txd        = txd_q;
  assign bit_end    = (cnt_q == CNT_LAST);
  assign idx_nxt    = idx_q + 3'd1;

  // FIFO data write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a push and a pop on one edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Serialiser registers; txd is registered so the line never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic; txd_d is the line level for the cycle after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = head;
          cnt_d   = '0;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = DATA;
          txd_d   = sh_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
          txd_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_nxt;
            txd_d = sh_q[idx_nxt];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          txd_d = sh_q[idx_q];
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (count_q != '0) begin
            // Chain straight into the next frame with no idle gap.
            pop     = 1'b1;
            sh_d    = head;
            state_d = START;
            txd_d   = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          txd_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Directed bench for uart_transmit with an 8-cycle bit period and a 4-deep FIFO.
// A behavioural receiver decodes txd and feeds the received-byte queue.
module tb_uart_transmit;

  localparam int CPB = 8;
  localparam int AW  = 2;

  logic          clk;
  logic          reset;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          busy;
  logic [AW:0]   fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  uart_transmit #(
    .CLKS_PER_BIT (CPB),
    .FIFO_AW      (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural 8N1 receiver: samples mid-bit, relative to the first low sample.
  int         rx_cnt;
  logic       rx_active;
  logic [7:0] rx_sh;
  logic       rx_done;
  int         rx_err    = 0;
  int         rx_frames = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
      rx_sh     <= 8'h00;
      rx_done   <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (!rx_active) begin
        if (txd === 1'b0) begin
          rx_active <= 1'b1;
          rx_cnt    <= 1;
        end
      end else begin
        rx_cnt <= rx_cnt + 1;
        if (rx_cnt == CPB / 2) begin
          if (txd !== 1'b0) rx_err <= rx_err + 1;
        end else if (rx_cnt >= CPB / 2 + CPB && rx_cnt <= CPB / 2 + 8 * CPB &&
                     ((rx_cnt - CPB / 2) % CPB) == 0) begin
          rx_sh <= {txd, rx_sh[7:1]};
        end else if (rx_cnt == CPB / 2 + 9 * CPB) begin
          if (txd !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(rx_sh);
          rx_done   <= 1'b1;
          rx_active <= 1'b0;
        end
      end
    end
  end

  // Completion-flag counter
  always @(posedge clk) begin
    if (rx_done) rx_frames <= rx_frames + 1;
  end

  // Driver and checking tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    logic [7:0] e;
    logic [7:0] a;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_rx_timeout"}, 32'(n < budget), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front();
      else a = 8'hxx;
      check({tag, "_byte"}, 32'(a), 32'(e));
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Directed sequence
  initial begin
    logic [9:0] frame;
    int bad;
    int frames_before;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    // Reset state
    repeat (3) tick();
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single byte 0xA5: push edge N, start bit begins at N+1
    exp_q.push_back(8'hA5);
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tick();
    tx_valid = 1'b0;
    check("single_count_after_push", 32'(fifo_count), 32'd1);
    check("single_txd_before_pop", 32'(txd), 32'd1);
    tick();
    check("single_txd_falls", 32'(txd), 32'd0);
    check("single_count_after_pop", 32'(fifo_count), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    repeat (CPB / 2) tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("single_bit%0d", k), 32'(txd), 32'(frame[k]));
      if (k < 9) repeat (CPB) tick();
    end
    repeat (3) tick();
    check("single_stop_last_txd", 32'(txd), 32'd1);
    check("single_stop_last_busy", 32'(busy), 32'd1);
    tick();
    check("single_end_busy", 32'(busy), 32'd0);
    check("single_end_txd", 32'(txd), 32'd1);
    drain("single", 200);

    // Back-to-back 0x00, 0xFF, 0x55 pushed on edges M, M+1, M+2.
    // The first pop coincides with the second push, so the count reads 1,1,2.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tick();
    check("b2b_count0", 32'(fifo_count), 32'd1);
    tx_data = 8'hFF;
    tick();
    check("b2b_count1", 32'(fifo_count), 32'd1);
    check("b2b_first_start", 32'(txd), 32'd0);
    tx_data = 8'h55;
    tick();
    tx_valid = 1'b0;
    check("b2b_count2", 32'(fifo_count), 32'd2);
    repeat (78) tick();
    check("b2b_f1_stop_txd", 32'(txd), 32'd1);
    check("b2b_count_before_f2", 32'(fifo_count), 32'd2);
    tick();
    check("b2b_f2_start_txd", 32'(txd), 32'd0);
    check("b2b_count_f2", 32'(fifo_count), 32'd1);
    repeat (80) tick();
    check("b2b_f3_start_txd", 32'(txd), 32'd0);
    check("b2b_count_f3", 32'(fifo_count), 32'd0);
    repeat (79) tick();
    check("b2b_last_stop_busy", 32'(busy), 32'd1);
    check("b2b_last_stop_txd", 32'(txd), 32'd1);
    tick();
    check("b2b_end_busy_240", 32'(busy), 32'd0);
    drain("b2b", 100);

    // Full FIFO: tx_valid held with 0x01..0x06
    for (int b = 1; b <= 6; b++) exp_q.push_back(8'(b));
    tx_valid = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      tx_data = 8'(b);
      tick();
    end
    tx_data = 8'h06;
    check("full_ready", 32'(tx_ready), 32'd0);
    check("full_count", 32'(fifo_count), 32'd4);
    repeat (76) tick();
    check("full_hold_ready", 32'(tx_ready), 32'd0);
    check("full_hold_count", 32'(fifo_count), 32'd4);
    tick();
    check("full_pop_ready", 32'(tx_ready), 32'd1);
    check("full_pop_count", 32'(fifo_count), 32'd3);
    tick();
    tx_valid = 1'b0;
    check("full_accept_count", 32'(fifo_count), 32'd4);
    check("full_accept_ready", 32'(tx_ready), 32'd0);
    drain("full", 1000);
    wait_idle("full", 200);

    // Simultaneous push/pop on the STOP->START edge
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h99);
    tx_valid = 1'b1;
    tx_data  = 8'h81;
    tick();
    tx_valid = 1'b0;
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h42;
    tick();
    tx_valid = 1'b0;
    check("sim_count_queued", 32'(fifo_count), 32'd1);
    repeat (78) tick();
    check("sim_count_before", 32'(fifo_count), 32'd1);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    tick();
    tx_valid = 1'b0;
    check("sim_count_after", 32'(fifo_count), 32'd1);
    check("sim_start_txd", 32'(txd), 32'd0);
    drain("sim", 400);
    wait_idle("sim", 200);

    // Reset mid-frame during DATA bit 3 of 0xF0 (bit 3 is 0) with 2 queued
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    tick();
    tx_valid = 1'b0;
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    tick();
    tx_data  = 8'h22;
    tick();
    tx_valid = 1'b0;
    repeat (33) tick();
    check("mid_txd_bit3", 32'(txd), 32'd0);
    check("mid_count", 32'(fifo_count), 32'd2);
    check("mid_busy", 32'(busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_txd", 32'(txd), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
    bad = 0;
    repeat (200) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("mid_quiet_200", 32'(bad), 32'd0);
    check("mid_no_rx", 32'(rx_q.size()), 32'd0);

    // Loopback 0x3C then 0xC3
    frames_before = rx_frames;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    tick();
    tx_data  = 8'hC3;
    tick();
    tx_valid = 1'b0;
    drain("loop", 400);
    wait_idle("loop", 200);
    check("loop_done_flags", 32'(rx_frames - frames_before), 32'd2);
    check("rx_framing_errors", 32'(rx_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
